// File: rtl/cpu_bus_responder_pkg.sv
// Shared constants and address-region decode for the CPU bus responder.
package cpu_bus_responder_pkg;

    localparam logic [17:0] IO_UART_ADDR = 18'h30000;
    localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_NONE
    } region_e;

    // I/O window wins over RAM when the RAM would otherwise overlap it.
    function automatic region_e region_of(input logic [17:0] a, input int aw);
        if (a[17:16] == 2'b11) begin
            return REG_IO;
        end else if (aw >= 18 || (a >> aw) == 18'd0) begin
            return REG_RAM;
        end
        return REG_NONE;
    endfunction

endpackage

// File: rtl/cpu_bus_responder_sync_fifo.sv
// Synchronous FIFO with occupancy count; pushes into a full FIFO are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok  = push && (count_q != CW'(DEPTH));
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok && !rst_in) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// Byte-wide CPU bus slave: RAM, UART TX/RX window, cycle counter and halt flag.
module cpu_bus_responder
    import cpu_bus_responder_pkg::*;
#(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] a_in,
    input  logic        wr_in,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_end
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic [17:0]   addr;
    region_e       region;
    logic          is_uart, is_clk;
    logic          ram_rd, ram_wr;
    logic [7:0]    ram [2**RAM_AW];
    logic [7:0]    ram_rd_q;
    logic          src_ram_q, src_ram_d;
    logic [7:0]    io_q, io_d;
    logic [31:0]   cycle_q, cycle_d;
    logic [31:0]   snap_q, snap_d;
    logic          end_q, end_d;
    logic          push;
    logic [7:0]    push_data;
    logic          tx_empty;
    logic [CW-1:0] tx_count;
    logic          unused_ok;

    assign addr      = a_in[17:0];
    assign unused_ok = ^a_in[31:18];
    assign region    = region_of(addr, RAM_AW);
    assign is_uart   = (region == REG_IO) && (addr == IO_UART_ADDR);
    assign is_clk    = (region == REG_IO) && (addr[17:2] == IO_CLK_ADDR[17:2]);
    assign ram_rd    = !rst_in && !wr_in && (region == REG_RAM);
    assign ram_wr    = !rst_in && wr_in && (region == REG_RAM);

    always_ff @(posedge clk_in) begin
        if (ram_wr) begin
            ram[a_in[RAM_AW-1:0]] <= d_in;
        end else if (ram_rd) begin
            ram_rd_q <= ram[a_in[RAM_AW-1:0]];
        end
    end

    always_comb begin
        src_ram_d = src_ram_q;
        io_d      = io_q;
        cycle_d   = cycle_q + 32'd1;
        snap_d    = snap_q;
        end_d     = end_q;
        push      = 1'b0;
        push_data = d_in;
        rx_pop    = 1'b0;
        if (!wr_in) begin
            src_ram_d = (region == REG_RAM);
            io_d      = 8'h00;
            if (is_uart) begin
                io_d   = rx_valid ? rx_data : 8'h00;
                rx_pop = rx_valid && !rst_in;
            end else if (is_clk) begin
                // Byte 0 latches the whole dword so bytes 1..3 stay coherent.
                if (addr[1:0] == 2'd0) begin
                    snap_d = cycle_q;
                    io_d   = cycle_q[7:0];
                end else begin
                    io_d = snap_q[8*addr[1:0] +: 8];
                end
            end
        end else if (region == REG_IO && !end_q && !rst_in) begin
            if (is_uart && d_in != 8'h00) begin
                push = 1'b1;
            end else if (addr == IO_CLK_ADDR) begin
                push      = 1'b1;
                push_data = 8'h00;
                end_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            src_ram_q <= 1'b0;
            io_q      <= 8'h00;
            cycle_q   <= '0;
            snap_q    <= '0;
            end_q     <= 1'b0;
        end else begin
            src_ram_q <= src_ram_d;
            io_q      <= io_d;
            cycle_q   <= cycle_d;
            snap_q    <= snap_d;
            end_q     <= end_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (push),
        .wdata  (push_data),
        .pop    (tx_valid && tx_ready),
        .rdata  (tx_data),
        .empty  (tx_empty),
        .count  (tx_count)
    );

    assign d_out          = src_ram_q ? ram_rd_q : io_q;
    assign tx_valid       = !tx_empty;
    assign io_buffer_full = (tx_count >= CW'(TX_DEPTH - 1));
    assign program_end    = end_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder with hand-computed expectations.
module tb_cpu_bus_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] a_in;
    logic        wr_in;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        program_end;

    int n_checks = 0;
    int n_pass   = 0;
    int pop_cnt  = 0;
    logic [7:0] txq [$];

    cpu_bus_responder #(
        .RAM_AW   (17),
        .TX_DEPTH (8)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .a_in           (a_in),
        .wr_in          (wr_in),
        .d_in           (d_in),
        .d_out          (d_out),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (rx_pop),
        .program_end    (program_end)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (!rst_in && tx_valid && tx_ready) txq.push_back(tx_data);
        if (rx_pop) pop_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic acc(input logic [31:0] a, input logic w, input logic [7:0] d);
        a_in  = a;
        wr_in = w;
        d_in  = d;
        @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) acc(32'h0, 1'b0, 8'h00);
    endtask

    task automatic pull(output logic [31:0] v);
        if (txq.size() > 0) v = {24'h0, txq.pop_front()};
        else v = 32'hFFFF_FFFF;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        a_in   = 32'h30000;
        wr_in  = 1'b1;
        d_in   = 8'h22;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        a_in   = 32'h0;
        wr_in  = 1'b0;
        d_in   = 8'h00;
    endtask

    logic [31:0] v;

    initial begin
        tx_ready = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        do_reset();
        check("rst_dout", d_out, 8'h00);
        check("rst_txv", tx_valid, 1'b0);
        check("rst_full", io_buffer_full, 1'b0);
        check("rst_end", program_end, 1'b0);
        check("rst_pop", rx_pop, 1'b0);

        acc(32'h00010, 1'b1, 8'hAB);
        acc(32'h00010, 1'b0, 8'h00);
        check("ram_10", d_out, 8'hAB);
        acc(32'h1FFFF, 1'b1, 8'h5C);
        check("ram_wr_hold", d_out, 8'hAB);
        acc(32'h1FFFF, 1'b0, 8'h00);
        check("ram_1ffff", d_out, 8'h5C);
        acc(32'h00000, 1'b1, 8'h12);
        acc(32'h20000, 1'b1, 8'h99);
        acc(32'h00000, 1'b0, 8'h00);
        check("unmap_wr", d_out, 8'h12);
        acc(32'h20000, 1'b0, 8'h00);
        check("unmap_rd", d_out, 8'h00);
        acc(32'hFFFC0010, 1'b0, 8'h00);
        check("hi_bits_ign", d_out, 8'hAB);

        txq.delete();
        acc(32'h30000, 1'b1, 8'h41);
        acc(32'h30000, 1'b1, 8'h00);
        acc(32'h30000, 1'b1, 8'h42);
        idle(4);
        check("uart_n", txq.size(), 2);
        pull(v);
        check("uart_b0", v, 8'h41);
        pull(v);
        check("uart_b1", v, 8'h42);

        acc(32'h30008, 1'b1, 8'h55);
        acc(32'h30010, 1'b0, 8'h00);
        idle(3);
        check("io_other_wr", txq.size(), 0);
        acc(32'h00010, 1'b0, 8'h00);
        acc(32'h30008, 1'b0, 8'h00);
        check("io_other_rd", d_out, 8'h00);

        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) acc(32'h30000, 1'b1, 8'h31 + 8'(i));
        check("bp_full6", io_buffer_full, 1'b0);
        acc(32'h30000, 1'b1, 8'h37);
        check("bp_full7", io_buffer_full, 1'b1);
        acc(32'h30000, 1'b1, 8'h38);
        acc(32'h30000, 1'b1, 8'h39);
        check("bp_full9", io_buffer_full, 1'b1);
        tx_ready = 1'b1;
        idle(12);
        check("bp_n", txq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            pull(v);
            check("bp_byte", v, 32'h31 + 32'(i));
        end
        check("bp_empty", tx_valid, 1'b0);

        pop_cnt  = 0;
        rx_valid = 1'b1;
        rx_data  = 8'h7A;
        acc(32'h30000, 1'b0, 8'h00);
        check("rx_data", d_out, 8'h7A);
        idle(2);
        check("rx_pop1", pop_cnt, 1);
        rx_valid = 1'b0;
        acc(32'h30000, 1'b0, 8'h00);
        check("rx_empty", d_out, 8'h00);
        idle(1);
        check("rx_nopop", pop_cnt, 1);

        txq.delete();
        acc(32'h30004, 1'b1, 8'h55);
        check("stop_end", program_end, 1'b1);
        idle(3);
        acc(32'h30000, 1'b1, 8'h41);
        idle(3);
        check("stop_n", txq.size(), 1);
        pull(v);
        check("stop_b0", v, 8'h00);
        acc(32'h00040, 1'b1, 8'hC3);
        acc(32'h00040, 1'b0, 8'h00);
        check("stop_ram", d_out, 8'hC3);

        do_reset();
        check("rst2_end", program_end, 1'b0);
        tx_ready = 1'b0;
        acc(32'h30000, 1'b1, 8'h11);
        check("mid_txv", tx_valid, 1'b1);
        do_reset();
        check("mid_flush", tx_valid, 1'b0);
        check("mid_dout", d_out, 8'h00);
        tx_ready = 1'b1;

        idle(100);
        acc(32'h30004, 1'b0, 8'h00);
        check("clk_b0", d_out, 8'h64);
        acc(32'h30005, 1'b0, 8'h00);
        check("clk_b1", d_out, 8'h00);
        acc(32'h30006, 1'b0, 8'h00);
        check("clk_b2", d_out, 8'h00);
        acc(32'h30007, 1'b0, 8'h00);
        check("clk_b3", d_out, 8'h00);

        do_reset();
        idle(255);
        acc(32'h30004, 1'b0, 8'h00);
        check("snap_b0", d_out, 8'hFF);
        acc(32'h30005, 1'b0, 8'h00);
        check("snap_b1", d_out, 8'h00);
        acc(32'h30004, 1'b0, 8'h00);
        check("snap2_b0", d_out, 8'h01);
        acc(32'h30005, 1'b0, 8'h00);
        check("snap2_b1", d_out, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
